// File: rtl/wb_bank_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bank_arbiter
//   Arbitrates NUM_PORTS pipelined Wishbone masters onto NUM_BANKS single-port
//   RAM banks. Each bank has its own round-robin pointer. A bank grant is
//   combinational, so the winner sees no stall in the same cycle. The accepted
//   beat is acknowledged one cycle later.
//   With HOLD_CYC=1 a bank stays with its first grantee until that port drops
//   wb_cyc_i. This gives a bus-lock for the whole Wishbone cycle.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   wb_cyc_i     per-port cycle-valid
//   wb_stb_i     per-port strobe
//   bank_sel_i   per-port target bank, slice [p*BANK_W +: BANK_W]
//                (values >= NUM_BANKS are ignored)
//   wb_stall_o   per-port: request present but not granted this cycle
//   wb_ack_o     per-port: beat accepted in the previous cycle completes
//   bank_en_o    per-bank: bank accessed this cycle
//   bank_port_o  per-bank: granted port, slice [b*PORT_W +: PORT_W] (0 if idle)
// -----------------------------------------------------------------------------
module wb_bank_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int NUM_BANKS = 2,
    parameter int HOLD_CYC  = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            wb_cyc_i,
    input  logic [NUM_PORTS-1:0]            wb_stb_i,
    input  logic [NUM_PORTS*((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] bank_sel_i,
    output logic [NUM_PORTS-1:0]            wb_stall_o,
    output logic [NUM_PORTS-1:0]            wb_ack_o,
    output logic [NUM_BANKS-1:0]            bank_en_o,
    output logic [NUM_BANKS*$clog2(NUM_PORTS)-1:0] bank_port_o
);

    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [BANK_W:0] NUM_BANKS_L = (BANK_W+1)'(NUM_BANKS);
    localparam logic [PORT_W:0] NUM_PORTS_L = (PORT_W+1)'(NUM_PORTS);
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    logic [BANK_W-1:0]                   sel_w [NUM_PORTS];
    logic [NUM_PORTS-1:0]                req;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0] gnt_mat;
    logic [NUM_PORTS-1:0]                granted;
    logic [NUM_PORTS-1:0]                ack_q;

    // Per-port request decode. Out-of-range bank selects are treated as idle.
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        assign sel_w[gi] = bank_sel_i[gi*BANK_W +: BANK_W];
        assign req[gi]   = wb_cyc_i[gi] & wb_stb_i[gi] & ({1'b0, sel_w[gi]} < NUM_BANKS_L);
    end

    // Per-bank arbiter: round-robin pointer plus optional owner lock.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [PORT_W-1:0]    rr_q, rr_d;
        logic                 own_vld_q, own_vld_d;
        logic [PORT_W-1:0]    own_port_q, own_port_d;
        logic                 owner_active;
        logic [NUM_PORTS-1:0] cand;
        logic                 found;
        logic [PORT_W-1:0]    win;

        // The lock only excludes other ports while the owner's cycle is still
        // open. When the owner drops cyc, the bank is free again in that same cycle.
        assign owner_active = (HOLD_CYC != 0) && own_vld_q && wb_cyc_i[own_port_q];

        always_comb begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                cand[p] = req[p] && (sel_w[p] == BANK_W'(gi))
                          && (!owner_active || (own_port_q == PORT_W'(p)));
            end
        end

        // Scan upward from the pointer, wrapping modulo NUM_PORTS.
        always_comb begin
            logic [PORT_W:0] idx;
            found = 1'b0;
            win   = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx = {1'b0, rr_q} + (PORT_W+1)'(i);
                if (idx >= NUM_PORTS_L) begin
                    idx = idx - NUM_PORTS_L;
                end
                if (!found && cand[idx[PORT_W-1:0]]) begin
                    found = 1'b1;
                    win   = idx[PORT_W-1:0];
                end
            end
        end

        always_comb begin
            rr_d       = rr_q;
            own_vld_d  = own_vld_q;
            own_port_d = own_port_q;
            if (found) begin
                rr_d = (win == LAST_PORT) ? '0 : win + 1'b1;
            end
            // The owner is (re)captured whenever the bank is not locked. A grant
            // in that state always goes to a port whose cyc is high.
            if (!owner_active) begin
                own_vld_d  = (HOLD_CYC != 0) && found;
                own_port_d = found ? win : own_port_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_q       <= '0;
                own_vld_q  <= 1'b0;
                own_port_q <= '0;
            end else begin
                rr_q       <= rr_d;
                own_vld_q  <= own_vld_d;
                own_port_q <= own_port_d;
            end
        end

        assign gnt_mat[gi]                        = found ? (NUM_PORTS'(1) << win) : '0;
        assign bank_en_o[gi]                      = found;
        assign bank_port_o[gi*PORT_W +: PORT_W]   = found ? win : '0;
    end

    // Each port targets a single bank, so at most one row sets each bit.
    always_comb begin
        granted = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            granted = granted | gnt_mat[b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= '0;
        end else begin
            ack_q <= granted;
        end
    end

    assign wb_stall_o = req & ~granted;
    // If the master drops cyc, the pending ack is suppressed (cycle abort).
    assign wb_ack_o   = ack_q & wb_cyc_i;

endmodule

// File: tb/tb_wb_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_bank_arbiter
//   Two instances share every input: u_rr (HOLD_CYC=0) and u_hold (HOLD_CYC=1).
//   Both use 4 ports and 3 banks, so a bank select of 3 is an invalid target.
//   A directed prologue with literal expectations comes first, then randomized
//   traffic. A reference model checks both instances on every falling edge.
// -----------------------------------------------------------------------------
module tb_wb_bank_arbiter;

    localparam int NP = 4;
    localparam int NB = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NP-1:0] cyc, stb;
    logic [2*NP-1:0] sel;

    logic [NP-1:0] st0, ak0, st1, ak1;
    logic [NB-1:0] en0, en1;
    logic [2*NB-1:0] pt0, pt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_bank_arbiter #(.NUM_PORTS(NP), .NUM_BANKS(NB), .HOLD_CYC(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .bank_sel_i(sel),
        .wb_stall_o(st0), .wb_ack_o(ak0), .bank_en_o(en0), .bank_port_o(pt0)
    );

    wb_bank_arbiter #(.NUM_PORTS(NP), .NUM_BANKS(NB), .HOLD_CYC(1)) u_hold (
        .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .bank_sel_i(sel),
        .wb_stall_o(st1), .wb_ack_o(ak1), .bank_en_o(en1), .bank_port_o(pt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (index h: 0 = no hold, 1 = hold) -------
    int          m_rr  [2][NB];
    bit          m_ov  [2][NB];
    int          m_op  [2][NB];
    int          m_win [2][NB];
    logic [NP-1:0] m_ack [2];
    logic [NP-1:0] m_gnt [2];

    function automatic bit is_req(int p);
        int s;
        s = int'(sel[p*2 +: 2]);
        return cyc[p] && stb[p] && (s < NB);
    endfunction

    always @(negedge clk) begin
        for (int h = 0; h < 2; h++) begin
            logic [NB-1:0]   e_en;
            logic [2*NB-1:0] e_pt;
            logic [NP-1:0]   e_gnt, e_req, e_stall, e_ack;
            e_en = '0; e_pt = '0; e_gnt = '0; e_req = '0;
            for (int p = 0; p < NP; p++) e_req[p] = is_req(p);
            for (int b = 0; b < NB; b++) begin
                bit locked;
                int w;
                locked = (h == 1) && m_ov[h][b] && cyc[m_op[h][b]];
                w = -1;
                for (int i = 0; i < NP; i++) begin
                    int p;
                    p = (m_rr[h][b] + i) % NP;
                    if (w < 0 && e_req[p] && int'(sel[p*2 +: 2]) == b
                        && (!locked || p == m_op[h][b]))
                        w = p;
                end
                m_win[h][b] = w;
                if (w >= 0) begin
                    e_en[b]        = 1'b1;
                    e_pt[b*2 +: 2] = 2'(w);
                    e_gnt[w]       = 1'b1;
                end
            end
            m_gnt[h] = e_gnt;
            e_stall  = e_req & ~e_gnt;
            e_ack    = m_ack[h] & cyc;
            if (h == 0) begin
                chk("m0_stall", 32'(st0), 32'(e_stall));
                chk("m0_ack",   32'(ak0), 32'(e_ack));
                chk("m0_en",    32'(en0), 32'(e_en));
                chk("m0_port",  32'(pt0), 32'(e_pt));
            end else begin
                chk("m1_stall", 32'(st1), 32'(e_stall));
                chk("m1_ack",   32'(ak1), 32'(e_ack));
                chk("m1_en",    32'(en1), 32'(e_en));
                chk("m1_port",  32'(pt1), 32'(e_pt));
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int h = 0; h < 2; h++) begin
            if (!rst_n) begin
                m_ack[h] = '0;
                for (int b = 0; b < NB; b++) begin
                    m_rr[h][b] = 0; m_ov[h][b] = 0; m_op[h][b] = 0;
                end
            end else begin
                m_ack[h] = m_gnt[h];
                for (int b = 0; b < NB; b++) begin
                    int w;
                    w = m_win[h][b];
                    if (w >= 0) m_rr[h][b] = (w + 1) % NP;
                    if (h == 1 && !(m_ov[h][b] && cyc[m_op[h][b]])) begin
                        m_ov[h][b] = (w >= 0);
                        if (w >= 0) m_op[h][b] = w;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; cyc = '0; stb = '0; sel = '0;

        // Reset with random inputs: no acks.
        repeat (3) begin
            step();
            cyc = NP'($urandom); stb = NP'($urandom); sel = (2*NP)'($urandom);
            #2;
            chk("reset_ack0", 32'(ak0), 32'h0);
            chk("reset_ack1", 32'(ak1), 32'h0);
        end

        // Release: P0 and P1 collide on bank0, P0 wins first.
        step();
        rst_n = 1'b1; cyc = 4'b0011; stb = 4'b0011; sel = 8'h00;
        #2;
        chk("t1_port",  32'(pt0[1:0]), 32'd0);
        chk("t1_stall", 32'(st0), 32'b0010);
        chk("t1_en",    32'(en0), 32'b001);

        // Round-robin alternation for the remaining 5 beats.
        for (int k = 1; k < 6; k++) begin
            step(); #2;
            chk("rr_stall", 32'(st0), (k % 2) ? 32'b0001 : 32'b0010);
            chk("rr_ack",   32'(ak0), (k % 2) ? 32'b0001 : 32'b0010);
            chk("hold_lock_stall", 32'(st1), 32'b0010);
        end

        // Abort: P1 granted last beat, cyc drops -> no ack.
        step(); cyc = '0; stb = '0; #2;
        chk("abort_ack", 32'(ak0), 32'h0);

        // No collision: P0..P2 to banks 0..2, P3 targets invalid bank 3.
        step(); cyc = 4'hF; stb = 4'hF; sel = 8'hE4; #2;
        chk("nc_en",    32'(en0), 32'b111);
        chk("nc_stall", 32'(st0), 32'h0);
        chk("nc_port",  32'(pt0), 32'h24);
        chk("nc_en_h",  32'(en1), 32'b111);
        step(); #2;
        chk("nc_ack",   32'(ak0), 32'b0111);

        // Invalid bank select only: nothing granted, nothing stalled, no ack.
        step(); cyc = 4'b0100; stb = 4'b0100; sel = 8'h30; #2;
        chk("inv_en",    32'(en0), 32'h0);
        chk("inv_stall", 32'(st0), 32'h0);
        step(); #2;
        chk("inv_ack",   32'(ak0), 32'h0);

        // Hold mode: P1 takes bank0, then idles with cyc high while P0 asks.
        step(); cyc = '0; stb = '0; sel = 8'h00;
        step(); cyc = 4'b0010; stb = 4'b0010; #2;
        chk("h_own_port", 32'(pt1[1:0]), 32'd1);
        step(); cyc = 4'b0011; stb = 4'b0001; #2;
        chk("h_stall_a",  32'(st1), 32'b0001);
        chk("nohold_go",  32'(st0), 32'h0);
        step(); #2;
        chk("h_stall_b",  32'(st1), 32'b0001);
        chk("h_idle_en",  32'(en1), 32'h0);
        step(); cyc = 4'b0001; stb = 4'b0001; #2;
        chk("h_release_stall", 32'(st1), 32'h0);
        chk("h_release_en",    32'(en1), 32'b001);
        step(); cyc = 4'b0011; stb = 4'b0011; #2;
        chk("h_new_owner", 32'(st1), 32'b0010);

        // Async reset mid-operation: the ack must fall without a clock edge.
        step(); cyc = '0; stb = '0;
        step(); cyc = 4'b0001; stb = 4'b0001;
        step(); stb = '0; #1;
        chk("pre_rst_ack", 32'(ak0), 32'b0001);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ack0", 32'(ak0), 32'h0);
        chk("async_rst_ack1", 32'(ak1), 32'h0);
        step();
        rst_n = 1'b1; cyc = 4'b0011; stb = 4'b0011; sel = 8'h00; #2;
        chk("post_rst_port",  32'(pt0[1:0]), 32'd0);
        chk("post_rst_stall", 32'(st0), 32'b0010);

        // Randomized traffic with occasional async reset pulses.
        repeat (1500) begin
            step();
            cyc   = NP'($urandom | $urandom);
            stb   = NP'($urandom | $urandom);
            sel   = (2*NP)'($urandom);
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
        end
        step(); rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
